// File: rtl/sigma_delta_mod2.sv
// -----------------------------------------------------------------------------
// sigma_delta_mod2
//
// Second-order 1-bit sigma-delta modulator. It takes Q1.15 samples from the
// interpolating filter chain at the oversampled rate and produces the 1-bit
// PDM stream for the DAC pin. Both integrators saturate instead of wrapping.
// A MUTE phase runs after reset and a RECOVER phase runs after an overload.
// In both phases the output toggles at 50% duty (analog zero) while the
// integrators are held at zero.
//
// Optional build macro:
//   SIGMA_DELTA_DITHER_EN - adds +/-1 LSB dither to the input. The dither sign
//                           comes from a 16-bit LFSR (taps 16,14,13,11;
//                           seed 0xACE1). Without it, x = data_in exactly.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset (overrides clk_enable)
//   clk_enable in   oversampled-rate strobe; state advances only when high
//   data_in    in   signed DATA_W-bit sample
//   ovl_clear  in   clears the sticky overload flag (a new overload wins)
//   pdm_out    out  registered 1-bit modulator output
//   overload   out  sticky overload flag
//   state      out  FSM state: 0=MUTE, 1=RUN, 2=RECOVER
// -----------------------------------------------------------------------------
module sigma_delta_mod2 #(
    parameter int DATA_W        = 16,
    parameter int ACC_W         = 24,
    parameter int MUTE_TICKS    = 256,
    parameter int RECOVER_TICKS = 64,
    parameter int OVL_LIMIT     = 2**(ACC_W-2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ovl_clear,
    output logic              pdm_out,
    output logic              overload,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_MUTE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Two guard bits hold int2 + int1 + feedback without overflowing, so the
    // saturation test can be made on the true sum.
    localparam int SUM_W     = ACC_W + 2;
    localparam int MAX_TICKS = (MUTE_TICKS > RECOVER_TICKS) ? MUTE_TICKS : RECOVER_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic signed [SUM_W-1:0] ACC_MAX   = SUM_W'((64'sd1 <<< (ACC_W-1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] ACC_MIN   = -ACC_MAX;
    localparam logic signed [SUM_W-1:0] FB_POS    = SUM_W'(64'sd1 <<< (DATA_W-1));
    localparam logic signed [SUM_W-1:0] FB_NEG    = -FB_POS;
    localparam logic signed [SUM_W-1:0] LIM_POS   = SUM_W'(64'(OVL_LIMIT));
    localparam logic signed [SUM_W-1:0] LIM_NEG   = -LIM_POS;
    localparam logic [CNT_W-1:0]        MUTE_LAST = CNT_W'(MUTE_TICKS - 1);
    localparam logic [CNT_W-1:0]        RECV_LAST = CNT_W'(RECOVER_TICKS - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   int1_q, int1_d;
    logic signed [ACC_W-1:0]   int2_q, int2_d;
    logic                      pdm_q, pdm_d;
    logic                      overload_q;
    logic                      ovl_set;

    logic signed [DATA_W-1:0]  x_sat;
    logic signed [SUM_W-1:0]   fb_ext;
    logic signed [SUM_W-1:0]   sum1, sum2;
    logic signed [SUM_W-1:0]   sum1_sat, sum2_sat;
    logic                      sat1, sat2, ovl_event;

    // ---------------------------------------------------------------- input
`ifdef SIGMA_DELTA_DITHER_EN
    localparam logic signed [DATA_W:0] DIN_MAX = (DATA_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [DATA_W:0] DIN_MIN = -DIN_MAX - (DATA_W+1)'(1);
    localparam logic signed [DATA_W:0] ONE_W   = (DATA_W+1)'(1);

    logic [15:0]             lfsr_q;
    logic                    lfsr_new;
    logic signed [DATA_W:0]  x_wide;

    assign lfsr_new = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // The LFSR runs in every state so the dither sequence depends only on
    // the number of enable ticks since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else if (clk_enable) begin
            lfsr_q <= {lfsr_new, lfsr_q[15:1]};
        end
    end

    always_comb begin
        x_wide = (DATA_W+1)'($signed(data_in));
        x_wide = lfsr_q[0] ? (x_wide + ONE_W) : (x_wide - ONE_W);
        if (x_wide > DIN_MAX) begin
            x_sat = DATA_W'(DIN_MAX);
        end else if (x_wide < DIN_MIN) begin
            x_sat = DATA_W'(DIN_MIN);
        end else begin
            x_sat = DATA_W'(x_wide);
        end
    end
`else
    assign x_sat = $signed(data_in);
`endif

    // ------------------------------------------------------------ datapath
    assign fb_ext = pdm_q ? FB_POS : FB_NEG;
    assign sum1   = SUM_W'(int1_q) + SUM_W'(x_sat) - fb_ext;
    assign sum2   = SUM_W'(int2_q) + SUM_W'(int1_q) - fb_ext;

    assign sat1     = (sum1 > ACC_MAX) || (sum1 < ACC_MIN);
    assign sat2     = (sum2 > ACC_MAX) || (sum2 < ACC_MIN);
    assign sum1_sat = (sum1 > ACC_MAX) ? ACC_MAX : (sum1 < ACC_MIN) ? ACC_MIN : sum1;
    assign sum2_sat = (sum2 > ACC_MAX) ? ACC_MAX : (sum2 < ACC_MIN) ? ACC_MIN : sum2;

    assign ovl_event = sat1 || sat2 || (sum2_sat > LIM_POS) || (sum2_sat < LIM_NEG);

    // --------------------------------------------------- next-state logic
    always_comb begin
        // NOTE: every output of this block gets a hold value first, so a path
        // that skips an assignment (e.g. clk_enable low) cannot infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        int1_d  = int1_q;
        int2_d  = int2_q;
        pdm_d   = pdm_q;
        ovl_set = 1'b0;

        if (clk_enable) begin
            case (state_q)
                ST_RUN: begin
                    // The sign of the saturated int2 sum decides the bit
                    // (int2_next >= 0 gives 1). It is decided on the overload
                    // tick as well.
                    pdm_d = ~sum2_sat[SUM_W-1];
                    if (ovl_event) begin
                        state_d = ST_RECOVER;
                        cnt_d   = '0;
                        int1_d  = '0;
                        int2_d  = '0;
                        ovl_set = 1'b1;
                    end else begin
                        int1_d = ACC_W'(sum1_sat);
                        int2_d = ACC_W'(sum2_sat);
                    end
                end
                ST_MUTE, ST_RECOVER: begin
                    pdm_d  = ~pdm_q;
                    int1_d = '0;
                    int2_d = '0;
                    if (cnt_q == ((state_q == ST_MUTE) ? MUTE_LAST : RECV_LAST)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_MUTE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ----------------------------------------------------------- registers
    // NOTE: state registers use non-blocking assignments so that every
    // always_ff block samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_MUTE;
            cnt_q   <= '0;
            int1_q  <= '0;
            int2_q  <= '0;
            pdm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int1_q  <= int1_d;
            int2_q  <= int2_d;
            pdm_q   <= pdm_d;
        end
    end

    // The overload flag is not gated by clk_enable, so software can clear it
    // at any time. A new overload event wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overload_q <= 1'b0;
        end else if (ovl_set) begin
            overload_q <= 1'b1;
        end else if (ovl_clear) begin
            overload_q <= 1'b0;
        end
    end

    assign pdm_out  = pdm_q;
    assign overload = overload_q;
    assign state    = state_q;

endmodule

// File: tb/tb_sigma_delta_mod2.sv
// -----------------------------------------------------------------------------
// tb_sigma_delta_mod2
//
// Self-checking bench for sigma_delta_mod2. It runs two instances:
// dut_a uses the default parameters, and dut_b has OVL_LIMIT=4096 so that it
// overloads readily. A behavioural model of the modulator, written with
// plain integer arithmetic, predicts every output on every cycle. Directed
// literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_sigma_delta_mod2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b0;
    logic [15:0] data_in = '0;
    logic        ovl_clear = 1'b0;
    logic        pdm_a, ovl_a, pdm_b, ovl_b;
    logic [1:0]  st_a, st_b;

    always #5 clk = ~clk;

    sigma_delta_mod2 dut_a (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .data_in(data_in),
        .ovl_clear(ovl_clear), .pdm_out(pdm_a), .overload(ovl_a), .state(st_a)
    );

    sigma_delta_mod2 #(.OVL_LIMIT(4096)) dut_b (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .data_in(data_in),
        .ovl_clear(ovl_clear), .pdm_out(pdm_b), .overload(ovl_b), .state(st_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ------------------------------------------------------------ model
    localparam longint AMAX = (64'sd1 <<< 23) - 1;
    localparam longint HALF = 64'sd32768;

    longint      m_i1[2], m_i2[2];
    bit          m_pdm[2], m_ovl[2];
    int          m_mode[2];          // 0 mute, 1 run, 2 recover
    int          m_cnt[2];
    longint      lim[2] = '{64'sd4194304, 64'sd4096};
    bit [15:0]   m_lfsr = 16'hACE1;
    bit          model_valid = 1'b0;

    function automatic longint clamp(input longint v, input longint hi);
        return (v > hi) ? hi : (v < -hi) ? -hi : v;
    endfunction

    always @(posedge clk) begin : model
        longint x, fb, a, b;
        bit     ovs;
        x = longint'($signed(data_in));
`ifdef SIGMA_DELTA_DITHER_EN
        x = x + (m_lfsr[0] ? 1 : -1);
        x = (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
`endif
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_i1[k] = 0; m_i2[k] = 0; m_pdm[k] = 0; m_ovl[k] = 0;
                m_mode[k] = 0; m_cnt[k] = 0;
            end
            m_lfsr = 16'hACE1;
            model_valid = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                ovs = 1'b0;
                if (clk_enable) begin
                    if (m_mode[k] != 1) begin
                        m_pdm[k] = !m_pdm[k];
                        m_cnt[k]++;
                        if (m_cnt[k] == ((m_mode[k] == 0) ? 256 : 64)) begin
                            m_mode[k] = 1;
                            m_cnt[k]  = 0;
                        end
                    end else begin
                        fb = m_pdm[k] ? HALF : -HALF;
                        a  = m_i1[k] + x - fb;
                        b  = m_i2[k] + m_i1[k] - fb;
                        ovs = (a != clamp(a, AMAX)) || (b != clamp(b, AMAX));
                        a  = clamp(a, AMAX);
                        b  = clamp(b, AMAX);
                        m_pdm[k] = (b >= 0);
                        if (b > lim[k] || -b > lim[k]) ovs = 1'b1;
                        if (ovs) begin
                            m_i1[k] = 0; m_i2[k] = 0; m_mode[k] = 2; m_cnt[k] = 0;
                        end else begin
                            m_i1[k] = a; m_i2[k] = b;
                        end
                    end
                end
                if (ovs) m_ovl[k] = 1'b1;
                else if (ovl_clear) m_ovl[k] = 1'b0;
            end
            if (clk_enable)
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    // ------------------------------------------------------- compare
    always @(negedge clk) begin
        if (model_valid) begin
            check("pdm_a",   pdm_a, m_pdm[0]);
            check("ovl_a",   ovl_a, m_ovl[0]);
            check("state_a", st_a,  m_mode[0]);
            check("pdm_b",   pdm_b, m_pdm[1]);
            check("ovl_b",   ovl_b, m_ovl[1]);
            check("state_b", st_b,  m_mode[1]);
        end
    end

    // -------------------------------------------------------- stimulus
    task automatic cycle(input bit e);
        clk_enable = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) cycle(1'b1);
        reset = 1'b0;
    endtask

    bit rec[296];
    bit run_seq[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int ones;
    bit found;
    bit held;

    initial begin
        // Reset, then MUTE and the first RUN ticks with data_in = 0.
        data_in = 16'sd0;
        do_reset();
        check("rst_state", st_a, 0);
        check("rst_pdm",   pdm_a, 0);
        check("rst_ovl",   ovl_a, 0);
        for (int t = 1; t <= 296; t++) begin
            cycle(1'b1);
            rec[t-1] = m_pdm[0];
            if (t == 1)   check("mute_first_pdm", pdm_a, 1);
            if (t == 2)   check("mute_second_pdm", pdm_a, 0);
            if (t == 255) check("mute_state_255", st_a, 0);
            if (t == 256) begin
                check("run_entry_state", st_a, 1);
                check("run_entry_pdm", pdm_a, 0);
            end
`ifndef SIGMA_DELTA_DITHER_EN
            if (t >= 257 && t <= 260) check("run_pdm_seq", pdm_a, run_seq[t-257]);
`endif
            if (t == 257) begin
                check("lowlim_state", st_b, 2);
                check("lowlim_ovl",   ovl_b, 1);
            end
        end

        // Density tests on the default instance.
        ones = 0;
        for (int t = 0; t < 1024; t++) begin cycle(1'b1); ones += int'(pdm_a); end
        check_range("ones_zero", ones, 508, 516);
        check("ovl_zero_run", ovl_a, 0);

        data_in = 16'sd16384;
        ones = 0;
        for (int t = 0; t < 1024; t++) begin cycle(1'b1); ones += int'(pdm_a); end
        check_range("ones_half_pos", ones, 762, 774);

        data_in = -16'sd16384;
        ones = 0;
        for (int t = 0; t < 1024; t++) begin cycle(1'b1); ones += int'(pdm_a); end
        check_range("ones_half_neg", ones, 250, 262);

        // Pulsed enable (1 in 4) must reproduce the continuous-enable run.
        data_in = 16'sd0;
        do_reset();
        for (int t = 0; t < 296; t++) begin
            cycle(1'b1);
            check("pulsed_pdm", pdm_a, rec[t]);
            held = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cycle(1'b0);
                if (pdm_a !== rec[t]) held = 1'b0;
            end
            check("pulsed_hold", held, 1);
        end

        // Overload on the low-limit instance: full-scale step.
        do_reset();
        data_in = 16'sd32767;
        repeat (256) cycle(1'b1);
        check("step_run_state", st_b, 1);
        found = 1'b0;
        for (int t = 0; t < 4 && !found; t++) begin
            cycle(1'b1);
            if (st_b == 2'd2 && ovl_b == 1'b1) found = 1'b1;
        end
        check("ovl_within_4", found, 1);
        for (int t = 1; t <= 64; t++) begin
            cycle(1'b1);
            if (t == 63) check("recover_63", st_b, 2);
            if (t == 64) check("recover_done", st_b, 1);
        end
        check("ovl_sticky", ovl_b, 1);
        ovl_clear = 1'b1;
        cycle(1'b0);
        ovl_clear = 1'b0;
        check("ovl_cleared", ovl_b, 0);

        // Reset while in RECOVER.
        cycle(1'b1);
        check("reovl_state", st_b, 2);
        repeat (3) cycle(1'b1);
        reset = 1'b1;
        cycle(1'b1);
        check("midrst_state", st_b, 0);
        check("midrst_ovl",   ovl_b, 0);
        check("midrst_pdm",   pdm_b, 0);
        reset = 1'b0;

`ifdef SIGMA_DELTA_DITHER_EN
        data_in = 16'sd0;
        do_reset();
        check("lfsr_seed", m_lfsr, 16'hACE1);
        cycle(1'b1);
        check("lfsr_one_tick", m_lfsr, 16'h5670);
        repeat (255) cycle(1'b1);
        ones = 0;
        for (int t = 0; t < 4096; t++) begin cycle(1'b1); ones += int'(pdm_a); end
        check_range("ones_dither", ones, 2032, 2064);
`endif

        cycle(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule
